// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared write-back constants, defaults and payload helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_DEF_WIDTH = 32;
    localparam int WB_DEF_NSRC  = 4;

    localparam int WB_ALU = 0;
    localparam int WB_IMM = 1;
    localparam int WB_MEM = 2;
    localparam int WB_PC4 = 3;

    localparam int WB_RD_W   = 5;
    // err + we + rd travel alongside the data word
    localparam int WB_META_W = WB_RD_W + 2;

    function automatic logic wb_qual_we(
        input logic               we,
        input logic [WB_RD_W-1:0] rd,
        input logic               sel_ok
    );
        return we && sel_ok && (rd != '0);
    endfunction

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_skid_buf.sv
// ============================================================================
// Module   : wb_skid_buf
// Brief    : Output register plus one skid entry; in_ready is purely registered.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_skid_buf #(
    parameter int PW = 39
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    logic          r_out_valid;
    logic [PW-1:0] r_out_pl;
    logic          r_skid_valid;
    logic [PW-1:0] r_skid_pl;

    logic          w_in_xfer;
    logic          w_out_free;

    assign w_in_xfer  = in_valid && !r_skid_valid;
    // Output register is free this edge when empty or being drained
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_pl     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pl    <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_pl     <= r_skid_pl;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out_valid  <= 1'b1;
                r_out_pl     <= in_payload;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_pl    <= in_payload;
        end
    end

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_payload = r_out_pl;

endmodule : wb_skid_buf

`default_nettype wire

// File: rtl/wb_sel_stage.sv
// ============================================================================
// Module   : wb_sel_stage
// Brief    : Write-back source select with range/x0 qualification and skid output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_sel_stage
    import wb_pkg::*;
#(
    parameter int WIDTH = WB_DEF_WIDTH,
    parameter int NSRC  = WB_DEF_NSRC,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [4:0]            out_rd,
    output logic                  out_we,
    output logic                  out_err
);

    localparam int c_pw = WIDTH + WB_META_W;

    logic [WIDTH-1:0] w_src [NSRC];
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_ok;
    logic             w_we_q;
    logic [c_pw-1:0]  w_in_pl;
    logic [c_pw-1:0]  w_out_pl;

    generate
        for (genvar k = 0; k < NSRC; k++) begin : g_src
            assign w_src[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Unmatched selects (>= NSRC) leave data at zero and flag the beat
    always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                w_sel_ok   = 1'b1;
                w_sel_data = w_src[k];
            end
        end
    end

    assign w_we_q  = wb_qual_we(in_we, in_rd, w_sel_ok);
    assign w_in_pl = {!w_sel_ok, w_we_q, in_rd, w_sel_data};

    wb_skid_buf #(
        .PW (c_pw)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (w_in_pl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (w_out_pl)
    );

    assign out_err  = w_out_pl[WIDTH+6];
    assign out_we   = w_out_pl[WIDTH+5];
    assign out_rd   = w_out_pl[WIDTH+4:WIDTH];
    assign out_data = w_out_pl[WIDTH-1:0];

endmodule : wb_sel_stage

`default_nettype wire
